divider_seq: RTL and testbench



---
 rtl/divider_seq.sv | 195 +++++++++++++++++++
 tb/tb_divider_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq
// Sequential restoring (shift-and-subtract) divider. One quotient bit is
// resolved per clock; a Width-bit division takes Width clocks in CALC.
//
// Optional build macro: DIV_SIGNED_EN
//   undefined : unsigned operands and results
//   defined   : two's complement operands, truncating (toward zero) results
//
// Parameters
//   Width        operand / quotient / remainder width in bits (>= 2)
//
// Ports
//   clk          system clock, rising edge active
//   rst_n        asynchronous reset, active low
//   start        request; only sampled while idle
//   dividend     numerator, latched when start is accepted
//   divisor      denominator, latched when start is accepted
//   quotient     registered result, held between done pulses
//   remainder    registered result, held between done pulses
//   busy         high while iterating
//   done         one-cycle pulse when quotient/remainder update
//   div_by_zero  sticky flag for the last operation, cleared on next accept
// -----------------------------------------------------------------------------
module divider_seq #(
  parameter int Width = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Width-1:0] dividend,
  input  logic [Width-1:0] divisor,
  output logic [Width-1:0] quotient,
  output logic [Width-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CountW = $clog2(Width);
  localparam logic [CountW-1:0] CountMax = CountW'(Width - 1);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t state, state_next;

  // Working registers: shift_q starts as the dividend and fills with quotient
  // bits from the LSB side; part_q is the partial remainder.
  logic [Width-1:0]  shift_q, shift_next;
  logic [Width-1:0]  dvsr_q, dvsr_next;
  logic [Width-1:0]  part_q, part_next;
  logic [CountW-1:0] count_q, count_next;

  logic [Width-1:0]  quotient_next, remainder_next;
  logic              busy_next, done_next, dbz_next;

  // One iteration of the restoring step.
  logic [Width:0]    shifted;
  logic              no_borrow;
  logic [Width-1:0]  part_step;
  logic [Width-1:0]  quot_step;

`ifdef DIV_SIGNED_EN
  // Sign bookkeeping for the magnitude engine.
  logic neg_quot_q, neg_quot_next;
  logic neg_rem_q, neg_rem_next;

  function automatic logic [Width-1:0] magnitude(input logic [Width-1:0] v);
    // The most-negative value maps onto itself, which read as unsigned is
    // exactly its magnitude.
    return v[Width-1] ? (~v + 1'b1) : v;
  endfunction
`endif

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_q     <= '0;
      dvsr_q      <= '0;
      part_q      <= '0;
      count_q     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      shift_q     <= shift_next;
      dvsr_q      <= dvsr_next;
      part_q      <= part_next;
      count_q     <= count_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      busy        <= busy_next;
      done        <= done_next;
      div_by_zero <= dbz_next;
`ifdef DIV_SIGNED_EN
      neg_quot_q  <= neg_quot_next;
      neg_rem_q   <= neg_rem_next;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_next     = state;
    shift_next     = shift_q;
    dvsr_next      = dvsr_q;
    part_next      = part_q;
    count_next     = count_q;
    quotient_next  = quotient;
    remainder_next = remainder;
    busy_next      = busy;
    done_next      = 1'b0;
    dbz_next       = div_by_zero;
`ifdef DIV_SIGNED_EN
    neg_quot_next  = neg_quot_q;
    neg_rem_next   = neg_rem_q;
`endif

    // Bring the next dividend bit into the partial remainder and try the
    // subtraction. The partial remainder is always below the divisor, so a
    // successful difference always fits back into Width bits.
    shifted   = {part_q, shift_q[Width-1]};
    no_borrow = (shifted >= {1'b0, dvsr_q});
    part_step = no_borrow ? Width'(shifted - {1'b0, dvsr_q}) : Width'(shifted);
    quot_step = {shift_q[Width-2:0], no_borrow};

    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Division by zero resolves immediately without iterating.
`ifdef DIV_SIGNED_EN
            quotient_next = dividend[Width-1] ? Width'(1) : '1;
`else
            quotient_next = '1;
`endif
            remainder_next = dividend;
            dbz_next       = 1'b1;
            done_next      = 1'b1;
          end else begin
`ifdef DIV_SIGNED_EN
            shift_next    = magnitude(dividend);
            dvsr_next     = magnitude(divisor);
            neg_quot_next = dividend[Width-1] ^ divisor[Width-1];
            neg_rem_next  = dividend[Width-1];
`else
            shift_next    = dividend;
            dvsr_next     = divisor;
`endif
            part_next  = '0;
            count_next = CountMax;
            busy_next  = 1'b1;
            dbz_next   = 1'b0;
            state_next = CALC;
          end
        end
      end

      CALC: begin
        shift_next = quot_step;
        part_next  = part_step;
        count_next = count_q - 1'b1;
        if (count_q == '0) begin
          // Last bit resolved: publish results and return to idle.
`ifdef DIV_SIGNED_EN
          quotient_next  = neg_quot_q ? (~quot_step + 1'b1) : quot_step;
          remainder_next = neg_rem_q  ? (~part_step + 1'b1) : part_step;
`else
          quotient_next  = quot_step;
          remainder_next = part_step;
`endif
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_divider_seq
// Self-checking bench for divider_seq. A transaction-level reference model
// predicts results with plain division and tracks when done must appear; a
// compare process checks every output on every falling edge. Directed cases
// additionally pin literal results and latencies.
// -----------------------------------------------------------------------------
module tb_divider_seq;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int checks = 0;
  int failures = 0;

  divider_seq #(.Width(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] exp_q = '0, exp_r = '0, pend_q = '0, pend_r = '0;
  logic         exp_busy = 1'b0, exp_done = 1'b0, exp_dbz = 1'b0;
  int           remaining = 0;

  function automatic void reference(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef DIV_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = (sa < 0) ? W'(1) : '1;
      r = a;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
`else
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  // Model: an accepted start schedules its result W edges later (or on the
  // accepting edge itself for a zero divisor); starts during a job are dropped.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q = '0; exp_r = '0; exp_busy = 1'b0; exp_done = 1'b0;
      exp_dbz = 1'b0; remaining = 0;
    end else begin
      exp_done = 1'b0;
      if (remaining > 0) begin
        remaining = remaining - 1;
        if (remaining == 0) begin
          exp_busy = 1'b0;
          exp_done = 1'b1;
          exp_q = pend_q;
          exp_r = pend_r;
        end
      end else if (start) begin
        if (divisor == '0) begin
          reference(dividend, divisor, exp_q, exp_r);
          exp_dbz = 1'b1;
          exp_done = 1'b1;
        end else begin
          reference(dividend, divisor, pend_q, pend_r);
          exp_dbz = 1'b0;
          exp_busy = 1'b1;
          remaining = W;
        end
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output with the model on each falling edge.
  always @(negedge clk) begin
    check_output("cmp_busy", int'(busy), int'(exp_busy));
    check_output("cmp_done", int'(done), int'(exp_done));
    check_output("cmp_dbz", int'(div_by_zero), int'(exp_dbz));
    check_output("cmp_quotient", int'(quotient), int'(exp_q));
    check_output("cmp_remainder", int'(remainder), int'(exp_r));
  end

  // Issue one division and wait (bounded) for done. Latency counts falling
  // edges after the first one following the accepting edge.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                output int latency);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    latency = 0;
    while (!done && latency < 4 * W) begin
      @(negedge clk);
      latency++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: done not seen after %0d cycles", latency);
    end
  endtask

  task automatic wait_done(output int latency);
    latency = 0;
    while (!done && latency < 4 * W) begin
      @(negedge clk);
      latency++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: done not seen after %0d cycles", latency);
    end
  endtask

  int lat;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_q", int'(quotient), 0);
    check_output("reset_r", int'(remainder), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef DIV_SIGNED_EN
    apply_stimulus(10'd1000, 10'd7, lat);
    check_output("lat_1000_7", lat, W);
    check_output("q_1000_7", int'(quotient), 142);
    check_output("r_1000_7", int'(remainder), 6);
    check_output("dbz_1000_7", int'(div_by_zero), 0);

    apply_stimulus(10'd5, 10'd0, lat);
    check_output("lat_div0", lat, 0);
    check_output("q_div0", int'(quotient), 1023);
    check_output("r_div0", int'(remainder), 5);
    check_output("dbz_div0", int'(div_by_zero), 1);

    apply_stimulus(10'd8, 10'd2, lat);
    check_output("q_8_2", int'(quotient), 4);
    check_output("r_8_2", int'(remainder), 0);
    check_output("dbz_cleared", int'(div_by_zero), 0);

    apply_stimulus(10'd3, 10'd9, lat);
    check_output("q_3_9", int'(quotient), 0);
    check_output("r_3_9", int'(remainder), 3);
    apply_stimulus(10'd1023, 10'd1, lat);
    check_output("q_1023_1", int'(quotient), 1023);
    check_output("r_1023_1", int'(remainder), 0);
    apply_stimulus(10'd0, 10'd5, lat);
    check_output("q_0_5", int'(quotient), 0);
    check_output("r_0_5", int'(remainder), 0);
    apply_stimulus(10'd1023, 10'd1023, lat);
    check_output("q_max_max", int'(quotient), 1);
    check_output("r_max_max", int'(remainder), 0);

    // Start during busy is ignored, start in the done cycle is accepted.
    @(negedge clk);
    dividend = 10'd100; divisor = 10'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 10'd600; divisor = 10'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = 10'd77; divisor = 10'd5;
    wait_done(lat);
    check_output("q_busy_ignore", int'(quotient), 11);
    check_output("r_busy_ignore", int'(remainder), 1);
    dividend = 10'd600; divisor = 10'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check_output("lat_back2back", lat, W);
    check_output("q_back2back", int'(quotient), 200);
    check_output("r_back2back", int'(remainder), 0);

    // Reset in the middle of an operation.
    @(negedge clk);
    dividend = 10'd900; divisor = 10'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_q", int'(quotient), 0);
    check_output("midrst_r", int'(remainder), 0);
    check_output("midrst_busy", int'(busy), 0);
    check_output("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    check_output("midrst_no_done", int'(done), 0);
    apply_stimulus(10'd900, 10'd13, lat);
    check_output("q_900_13", int'(quotient), 69);
    check_output("r_900_13", int'(remainder), 3);
`else
    apply_stimulus(W'(-7), 10'd2, lat);
    check_output("lat_s_m7_2", lat, W);
    check_output("q_s_m7_2", int'($signed(quotient)), -3);
    check_output("r_s_m7_2", int'($signed(remainder)), -1);
    apply_stimulus(10'd7, W'(-2), lat);
    check_output("q_s_7_m2", int'($signed(quotient)), -3);
    check_output("r_s_7_m2", int'($signed(remainder)), 1);
    apply_stimulus(W'(-512), W'(-1), lat);
    check_output("q_s_minneg", int'($signed(quotient)), -512);
    check_output("r_s_minneg", int'($signed(remainder)), 0);
    apply_stimulus(W'(-5), 10'd0, lat);
    check_output("q_s_div0_neg", int'($signed(quotient)), 1);
    check_output("dbz_s_div0", int'(div_by_zero), 1);
    apply_stimulus(10'd5, 10'd0, lat);
    check_output("q_s_div0_pos", int'($signed(quotient)), -1);
    check_output("r_s_div0_pos", int'($signed(remainder)), 5);
`endif

    // Randomised traffic: random starts (including during busy), occasional
    // zero divisors and boundary operands; the compare process does the work.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: dividend = '1;
        1: dividend = '0;
        default: dividend = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: divisor = '0;
        1: divisor = W'(1);
        2: divisor = '1;
        default: divisor = W'($urandom);
      endcase
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2 * W) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
